// File: rtl/miller_line_encoder.sv
// rtl/miller_line_encoder.sv - serial bit stream to Miller/FM0/Manchester/NRZ line-code encoder
//
// Purpose:
//   Takes one bit at a time over a valid/ready/last handshake and drives a line-coded
//   waveform on tx_out. Each encoded bit lasts CLKS_PER_BIT clocks, split into two equal
//   halves. Frames are delimited by s_last. An optional encoded dummy '1' can be appended
//   after the final bit. Outside a frame the line rests at IDLE_LEVEL.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   mode[1:0]   0=Miller 1=FM0 2=Manchester 3=NRZ, latched when a frame starts
//   s_data      input bit
//   s_valid     s_data/s_last valid
//   s_last      marks the final bit of the frame
//   s_ready     registered, 1 = single-entry holding register empty
//   tx_out      registered encoded line output
//   tx_active   1 while a frame (including any dummy bit) is on the line
//   underrun    1-cycle pulse: a bit period ended with no next bit and no last seen
//   frame_done  1-cycle pulse: the last bit (or dummy bit) period ended normally

module miller_line_encoder #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit IDLE_LEVEL   = 1'b0,
    parameter bit END_DUMMY    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_out,
    output logic       tx_active,
    output logic       underrun,
    output logic       frame_done
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] MODE_MILLER = 2'd0;
    localparam logic [1:0] MODE_FM0    = 2'd1;
    localparam logic [1:0] MODE_MANCH  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // Returns {first_half, second_half} for bit b, given the last driven level lvl
    // and the previous bit p (only Miller looks at p).
    function automatic logic [1:0] encode_bit(input logic [1:0] m, input logic lvl,
                                              input logic b, input logic p);
        logic first;
        logic second;
        first  = b;
        second = b;
        case (m)
            MODE_MILLER: begin
                // Transition at the boundary only between two consecutive zeros.
                first  = (!b && !p) ? !lvl : lvl;
                second = b ? !first : first;
            end
            MODE_FM0: begin
                // Always a boundary transition; mid-bit transition encodes a zero.
                first  = !lvl;
                second = b ? first : !first;
            end
            MODE_MANCH: begin
                first  = b;
                second = !b;
            end
            default: begin
                first  = b;
                second = b;
            end
        endcase
        return {first, second};
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           cur_last_q, cur_last_d;
    logic           prev_level_q, prev_level_d;
    logic           prev_bit_q, prev_bit_d;
    logic           second_q, second_d;
    logic           tx_q, tx_d;
    logic           active_q, active_d;
    logic           underrun_q, underrun_d;
    logic           done_q, done_d;
    logic           hold_full_q, hold_full_d;
    logic           hold_data_q, hold_data_d;
    logic           hold_last_q, hold_last_d;
    logic           s_ready_q, s_ready_d;

    logic           accept;
    logic           consume;
    logic [1:0]     enc_mode;
    logic           enc_level;
    logic           enc_prev;
    logic           enc_bit;
    logic [1:0]     enc;

    assign accept = s_valid && s_ready_q;

    // A new frame encodes with the live mode input and the idle history; inside a
    // frame the latched mode and the running history are used. When a last bit ends
    // in RUN, the only thing that can be encoded next is the dummy '1'.
    always_comb begin
        enc_mode  = mode_q;
        enc_level = prev_level_q;
        enc_prev  = prev_bit_q;
        enc_bit   = hold_data_q;
        if (state_q == ST_IDLE) begin
            enc_mode  = mode;
            enc_level = IDLE_LEVEL;
            enc_prev  = 1'b1;
        end else if (cur_last_q) begin
            enc_bit = 1'b1;
        end
        enc = encode_bit(enc_mode, enc_level, enc_bit, enc_prev);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        cur_last_d   = cur_last_q;
        prev_level_d = prev_level_q;
        prev_bit_d   = prev_bit_q;
        second_d     = second_q;
        tx_d         = tx_q;
        active_d     = active_q;
        underrun_d   = 1'b0;
        done_d       = 1'b0;
        consume      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    consume      = 1'b1;
                    state_d      = ST_RUN;
                    mode_d       = mode;
                    cnt_d        = '0;
                    tx_d         = enc[1];
                    second_d     = enc[0];
                    prev_level_d = enc[0];
                    prev_bit_d   = hold_data_q;
                    cur_last_d   = hold_last_q;
                    active_d     = 1'b1;
                end
            end

            ST_RUN, ST_TAIL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MID) begin
                    tx_d = second_q;
                end
                if (cnt_q == CNT_LAST) begin
                    if (state_q == ST_RUN && cur_last_q && END_DUMMY) begin
                        state_d      = ST_TAIL;
                        cnt_d        = '0;
                        tx_d         = enc[1];
                        second_d     = enc[0];
                        prev_level_d = enc[0];
                        prev_bit_d   = 1'b1;
                    end else if (state_q == ST_RUN && !cur_last_q && hold_full_q) begin
                        consume      = 1'b1;
                        cnt_d        = '0;
                        tx_d         = enc[1];
                        second_d     = enc[0];
                        prev_level_d = enc[0];
                        prev_bit_d   = hold_data_q;
                        cur_last_d   = hold_last_q;
                    end else begin
                        // Either the frame ended normally or the source starved us.
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        tx_d     = IDLE_LEVEL;
                        active_d = 1'b0;
                        if (state_q == ST_TAIL || cur_last_q) begin
                            done_d = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                tx_d     = IDLE_LEVEL;
                active_d = 1'b0;
            end
        endcase
    end

    // Holding register: consume and accept never coincide in practice because
    // s_ready tracks emptiness, but the update is written to be safe either way.
    always_comb begin
        hold_full_d = hold_full_q && !consume;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = s_data;
            hold_last_d = s_last;
        end
        s_ready_d = !hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mode_q       <= MODE_MILLER;
            cur_last_q   <= 1'b0;
            prev_level_q <= IDLE_LEVEL;
            prev_bit_q   <= 1'b1;
            second_q     <= IDLE_LEVEL;
            tx_q         <= IDLE_LEVEL;
            active_q     <= 1'b0;
            underrun_q   <= 1'b0;
            done_q       <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            cur_last_q   <= cur_last_d;
            prev_level_q <= prev_level_d;
            prev_bit_q   <= prev_bit_d;
            second_q     <= second_d;
            tx_q         <= tx_d;
            active_q     <= active_d;
            underrun_q   <= underrun_d;
            done_q       <= done_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            s_ready_q    <= s_ready_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign tx_out     = tx_q;
    assign tx_active  = active_q;
    assign underrun   = underrun_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_miller_line_encoder.sv
// tb/tb_miller_line_encoder.sv - directed self-checking bench for miller_line_encoder

module tb_miller_line_encoder;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       s_data;
    logic       s_valid;
    logic       s_valid_d;
    logic       s_last;
    logic       s_ready, tx_out, tx_active, underrun, frame_done;
    logic       s_ready_d, tx_out_d, tx_active_d, underrun_d, frame_done_d;

    int vectors;
    int miscompares;

    bit   sel_d;
    logic wave[$];
    int   n_under, n_done, n_under_active, n_done_active;
    logic tx_after, act_after, under_exit, done_exit;
    bit   cap_to, feed_to;
    time  t_acc, t_first;

    miller_line_encoder #(.CLKS_PER_BIT(16), .IDLE_LEVEL(1'b0), .END_DUMMY(1'b0)) dut (
        .clk(clk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .tx_out(tx_out), .tx_active(tx_active),
        .underrun(underrun), .frame_done(frame_done)
    );

    miller_line_encoder #(.CLKS_PER_BIT(16), .IDLE_LEVEL(1'b0), .END_DUMMY(1'b1)) dut_d (
        .clk(clk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid_d),
        .s_last(s_last), .s_ready(s_ready_d), .tx_out(tx_out_d), .tx_active(tx_active_d),
        .underrun(underrun_d), .frame_done(frame_done_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic f_rdy();  return sel_d ? s_ready_d    : s_ready;    endfunction
    function automatic logic f_act();  return sel_d ? tx_active_d  : tx_active;  endfunction
    function automatic logic f_tx();   return sel_d ? tx_out_d     : tx_out;     endfunction
    function automatic logic f_und();  return sel_d ? underrun_d   : underrun;   endfunction
    function automatic logic f_done(); return sel_d ? frame_done_d : frame_done; endfunction

    // Presents bits[0], bits[1], ... in order with valid held high; called at a negedge.
    task automatic feed(input int n, input logic [15:0] bits, input bit with_last);
        int guard;
        feed_to = 0;
        for (int i = 0; i < n; i++) begin
            s_data = bits[i];
            s_last = with_last && (i == n - 1);
            if (sel_d) s_valid_d = 1'b1; else s_valid = 1'b1;
            guard = 0;
            while (f_rdy() !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) feed_to = 1;
            if (i == 0) t_acc = $time;
            @(negedge clk);
        end
        s_valid   = 1'b0;
        s_valid_d = 1'b0;
        s_last    = 1'b0;
    endtask

    // Records tx_out once per cycle while tx_active is high, plus pulses around it.
    task automatic capture();
        int guard;
        wave.delete();
        n_under = 0; n_done = 0; n_under_active = 0; n_done_active = 0; cap_to = 0;
        guard = 0;
        while (f_act() !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) cap_to = 1;
        t_first = $time;
        while (f_act() === 1'b1 && wave.size() < 400) begin
            wave.push_back(f_tx());
            if (f_und() === 1'b1) n_under_active++;
            if (f_done() === 1'b1) n_done_active++;
            @(negedge clk);
        end
        tx_after   = f_tx();
        act_after  = f_act();
        under_exit = f_und();
        done_exit  = f_done();
        for (int k = 0; k < 4; k++) begin
            if (f_und() === 1'b1) n_under++;
            if (f_done() === 1'b1) n_done++;
            @(negedge clk);
        end
        n_under += n_under_active;
        n_done  += n_done_active;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; s_data = 1'b0; s_valid = 1'b0; s_valid_d = 1'b0; s_last = 1'b0;
        sel_d = 0;
        repeat (3) @(negedge clk);
        vectors++; if (tx_out !== 1'b0) begin miscompares++; $display("FAIL rst_tx_out got %b exp 0", tx_out); end
        vectors++; if (tx_active !== 1'b0) begin miscompares++; $display("FAIL rst_tx_active got %b exp 0", tx_active); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        vectors++; if (underrun !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++; $display("FAIL rst_pulses got und=%b done=%b exp 0 0", underrun, frame_done);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_rise got %b exp 1", s_ready); end
    endtask

    task automatic test_miller();
        logic [0:9] exp;
        bit ok;
        exp = 10'b0110001110;
        mode = 2'd0; sel_d = 0;
        fork
            feed(5, 16'b10011, 1);
            capture();
        join
        vectors++; if (cap_to || feed_to) begin miscompares++; $display("FAIL t1_timeout got cap=%0d feed=%0d exp 0 0", cap_to, feed_to); end
        vectors++; if (wave.size() != 80) begin miscompares++; $display("FAIL t1_len got %0d exp 80", wave.size()); end
        for (int k = 0; k < 10; k++) begin
            ok = 1;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j >= wave.size() || wave[k * 8 + j] !== exp[k]) ok = 0;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL t1_half%0d got %b exp %b", k, (k * 8 + 4 < wave.size()) ? wave[k * 8 + 4] : 1'bx, exp[k]); end
        end
        vectors++; if (n_under != 0) begin miscompares++; $display("FAIL t1_underrun got %0d exp 0", n_under); end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL t1_frame_done got %0d exp 1", n_done); end
        vectors++; if (tx_after !== 1'b0) begin miscompares++; $display("FAIL t1_idle_level got %b exp 0", tx_after); end
    endtask

    task automatic test_fm0();
        logic [0:5] exp;
        bit ok;
        exp = 6'b101100;
        mode = 2'd1; sel_d = 0;
        fork
            feed(3, 16'b110, 1);
            capture();
        join
        vectors++; if (cap_to || feed_to) begin miscompares++; $display("FAIL t2_timeout got cap=%0d feed=%0d exp 0 0", cap_to, feed_to); end
        vectors++; if (wave.size() != 48) begin miscompares++; $display("FAIL t2_active_len got %0d exp 48", wave.size()); end
        for (int k = 0; k < 6; k++) begin
            ok = 1;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j >= wave.size() || wave[k * 8 + j] !== exp[k]) ok = 0;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL t2_half%0d got %b exp %b", k, (k * 8 + 4 < wave.size()) ? wave[k * 8 + 4] : 1'bx, exp[k]); end
        end
        vectors++; if (tx_after !== 1'b0 || n_done != 1) begin
            miscompares++; $display("FAIL t2_end got tx=%b done=%0d exp 0 1", tx_after, n_done);
        end
    endtask

    // Manchester frame; mode is switched to Miller mid-frame and must be ignored.
    task automatic test_manchester();
        logic [0:3] exp;
        bit ok;
        int lat;
        exp = 4'b1001;
        mode = 2'd2; sel_d = 0;
        fork
            feed(2, 16'b01, 1);
            capture();
            begin
                repeat (12) @(negedge clk);
                mode = 2'd0;
            end
        join
        lat = int'((t_first - t_acc) / 10);
        vectors++; if (cap_to || feed_to) begin miscompares++; $display("FAIL t3_timeout got cap=%0d feed=%0d exp 0 0", cap_to, feed_to); end
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL t3_latency got %0d exp 2", lat); end
        vectors++; if (wave.size() != 32) begin miscompares++; $display("FAIL t3_len got %0d exp 32", wave.size()); end
        for (int k = 0; k < 4; k++) begin
            ok = 1;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j >= wave.size() || wave[k * 8 + j] !== exp[k]) ok = 0;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL t3_half%0d got %b exp %b", k, (k * 8 + 4 < wave.size()) ? wave[k * 8 + 4] : 1'bx, exp[k]); end
        end
    endtask

    task automatic test_underrun();
        logic [0:3] exp;
        bit ok;
        exp = 4'b0111;
        mode = 2'd0; sel_d = 0;
        fork
            feed(2, 16'b01, 0);
            capture();
        join
        vectors++; if (cap_to || feed_to) begin miscompares++; $display("FAIL t4_timeout got cap=%0d feed=%0d exp 0 0", cap_to, feed_to); end
        vectors++; if (wave.size() != 32) begin miscompares++; $display("FAIL t4_len got %0d exp 32", wave.size()); end
        for (int k = 0; k < 4; k++) begin
            ok = 1;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j >= wave.size() || wave[k * 8 + j] !== exp[k]) ok = 0;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL t4_half%0d got %b exp %b", k, (k * 8 + 4 < wave.size()) ? wave[k * 8 + 4] : 1'bx, exp[k]); end
        end
        vectors++; if (under_exit !== 1'b1 || n_under != 1) begin
            miscompares++; $display("FAIL t4_underrun got exit=%b count=%0d exp 1 1", under_exit, n_under);
        end
        vectors++; if (n_done != 0) begin miscompares++; $display("FAIL t4_frame_done got %0d exp 0", n_done); end
        vectors++; if (tx_after !== 1'b0 || act_after !== 1'b0) begin
            miscompares++; $display("FAIL t4_idle got tx=%b act=%b exp 0 0", tx_after, act_after);
        end
    endtask

    task automatic test_end_dummy();
        logic [0:3] exp;
        bit ok;
        exp = 4'b0001;
        mode = 2'd0; sel_d = 1;
        fork
            feed(1, 16'b0, 1);
            capture();
        join
        sel_d = 0;
        vectors++; if (cap_to || feed_to) begin miscompares++; $display("FAIL t5_timeout got cap=%0d feed=%0d exp 0 0", cap_to, feed_to); end
        vectors++; if (wave.size() != 32) begin miscompares++; $display("FAIL t5_len got %0d exp 32", wave.size()); end
        for (int k = 0; k < 4; k++) begin
            ok = 1;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j >= wave.size() || wave[k * 8 + j] !== exp[k]) ok = 0;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL t5_half%0d got %b exp %b", k, (k * 8 + 4 < wave.size()) ? wave[k * 8 + 4] : 1'bx, exp[k]); end
        end
        vectors++; if (done_exit !== 1'b1 || n_done_active != 0 || n_done != 1) begin
            miscompares++; $display("FAIL t5_frame_done got exit=%b inframe=%0d total=%0d exp 1 0 1", done_exit, n_done_active, n_done);
        end
    endtask

    task automatic test_reset_midframe();
        logic [0:3] exp;
        bit ok;
        int guard;
        int pulses;
        exp = 4'b0011;
        mode = 2'd0; sel_d = 0;
        pulses = 0;
        fork
            feed(3, 16'b011, 1);
            begin
                guard = 0;
                while (tx_active !== 1'b1 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                repeat (21) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
            end
        join
        vectors++; if (guard >= 100 || feed_to) begin miscompares++; $display("FAIL t6_timeout got guard=%0d feed=%0d exp <100 0", guard, feed_to); end
        vectors++; if (tx_out !== 1'b0 || tx_active !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++; $display("FAIL t6_abort got tx=%b act=%b rdy=%b exp 0 0 0", tx_out, tx_active, s_ready);
        end
        for (int k = 0; k < 3; k++) begin
            if (underrun === 1'b1 || frame_done === 1'b1) pulses++;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (underrun === 1'b1 || frame_done === 1'b1) pulses++;
            @(negedge clk);
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL t6_no_pulse got %0d exp 0", pulses); end
        fork
            feed(2, 16'b00, 1);
            capture();
        join
        vectors++; if (cap_to || feed_to) begin miscompares++; $display("FAIL t6b_timeout got cap=%0d feed=%0d exp 0 0", cap_to, feed_to); end
        for (int k = 0; k < 4; k++) begin
            ok = 1;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j >= wave.size() || wave[k * 8 + j] !== exp[k]) ok = 0;
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL t6_half%0d got %b exp %b", k, (k * 8 + 4 < wave.size()) ? wave[k * 8 + 4] : 1'bx, exp[k]); end
        end
        vectors++; if (n_done != 1 || wave.size() != 32) begin
            miscompares++; $display("FAIL t6_frame got done=%0d len=%0d exp 1 32", n_done, wave.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_miller();
        test_fm0();
        test_manchester();
        test_underrun();
        test_end_dummy();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
